// File: rtl/fsm_rr_scheduler.sv
// fsm_rr_scheduler: round-robin front end for a shared IDLE/RUN/DONE counter
// engine. One pending requester is picked in IDLE. Its run length is latched,
// and the engine runs for that many cycles. The owner then gets a one-cycle
// done pulse, and priority rotates past it.
// Optional feature macro: SCHED_ABORT_EN adds i_abort, which aborts a run
// early without a done pulse.
module fsm_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int CNT_BIT = 7
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [NUM_REQ*CNT_BIT-1:0] i_num_cnt,
`ifdef SCHED_ABORT_EN
  input  logic                       i_abort,
`endif
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [NUM_REQ-1:0]         o_done,
  output logic                       o_idle,
  output logic                       o_running,
  output logic [CNT_BIT-1:0]         o_cnt_val,
  output logic [1:0]                 c_state
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [CNT_BIT-1:0] n_q;
  logic [CNT_BIT-1:0] cnt_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] done_q;
  logic               idle_q;
  logic               running_q;

  logic [IDX_W-1:0]   win_idx_d;
  logic [CNT_BIT-1:0] win_n_d;
  logic               win_found_d;
  logic               abort_d;
  int                 cand;

`ifdef SCHED_ABORT_EN
  assign abort_d = i_abort;
`else
  assign abort_d = 1'b0;
`endif

  // Winner search: the first pending requester after the last-served index.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    win_idx_d   = '0;
    win_found_d = 1'b0;
    cand        = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(ptr_q) + i) % NUM_REQ;
      if (!win_found_d && i_req[cand]) begin
        win_found_d = 1'b1;
        win_idx_d   = IDX_W'(cand);
      end
    end
    win_n_d = i_num_cnt[int'(win_idx_d)*CNT_BIT +: CNT_BIT];
  end

  // Scheduler FSM; outputs are registered alongside the state they belong to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples pre-edge values regardless of statement order.
      state_q   <= S_IDLE;
      owner_q   <= '0;
      ptr_q     <= IDX_W'(NUM_REQ - 1);
      n_q       <= '0;
      cnt_q     <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      idle_q    <= 1'b1;
      running_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_found_d) begin
            owner_q <= win_idx_d;
            n_q     <= win_n_d;
            cnt_q   <= '0;
            grant_q <= NUM_REQ'(1) << win_idx_d;
            idle_q  <= 1'b0;
            if (win_n_d != '0) begin
              state_q   <= S_RUN;
              running_q <= 1'b1;
            end else begin
              state_q <= S_DONE;
              done_q  <= NUM_REQ'(1) << win_idx_d;
            end
          end
        end
        S_RUN: begin
          if (abort_d) begin
            state_q   <= S_IDLE;
            ptr_q     <= owner_q;
            cnt_q     <= '0;
            grant_q   <= '0;
            running_q <= 1'b0;
            idle_q    <= 1'b1;
          end else if (cnt_q == n_q - CNT_BIT'(1)) begin
            state_q   <= S_DONE;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= grant_q;
          end else begin
            cnt_q <= cnt_q + CNT_BIT'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          ptr_q   <= owner_q;
          grant_q <= '0;
          done_q  <= '0;
          idle_q  <= 1'b1;
        end
        default: begin
          // The unused encoding 2'b11 recovers to IDLE with idle outputs.
          state_q   <= S_IDLE;
          cnt_q     <= '0;
          grant_q   <= '0;
          done_q    <= '0;
          idle_q    <= 1'b1;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_grant   = grant_q;
  assign o_done    = done_q;
  assign o_idle    = idle_q;
  assign o_running = running_q;
  assign o_cnt_val = cnt_q;
  assign c_state   = state_q;

endmodule
